// File: rtl/ann_load_scheduler.sv
// ann_load_scheduler: sequences coefficient-set loads over the verification bus and runs the ANN
module ann_load_scheduler #(
    parameter int NUM_SETS = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bus_busy,
    input  logic       ann_request,
    input  logic [1:0] ann_select,
    input  logic       ann_done,
    input  logic [7:0] ann_seven_seg,
    output logic       bus_get_data,
    output logic [1:0] bus_which_data,
    output logic       loaded_pulse,
    output logic       ann_start,
    output logic [7:0] seven_seg,
    output logic       done,
    output logic       error,
    output logic       active
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_HI, WAIT_LO, RUN, ERROR} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          pend, pend_nx;
    logic [1:0]    pend_sel, pend_sel_nx;
    logic [1:0]    sel_nx;
    logic          loaded_once;
    logic          req_v, sel_ok, tmo, ld, finish;
    logic [1:0]    req_sel;

    // next state, select and pending request; a pending request acts as a live one in RUN
    always_comb begin
        state_nx    = state;
        sel_nx      = bus_which_data;
        pend_nx     = pend;
        pend_sel_nx = pend_sel;
        req_v       = ann_request | pend;
        req_sel     = ann_request ? ann_select : pend_sel;
        sel_ok      = int'(req_sel) < NUM_SETS;
        tmo         = ({1'b0, cnt} + (CW + 1)'(1)) == (CW + 1)'(TIMEOUT);
        case (state)
            IDLE, ERROR: if (start) begin
                state_nx = REQ;
                sel_nx   = 2'd0;
            end
            REQ:     state_nx = WAIT_HI;
            WAIT_HI: state_nx = bus_busy ? WAIT_LO : tmo ? ERROR : WAIT_HI;
            WAIT_LO: state_nx = !bus_busy ? RUN : tmo ? ERROR : WAIT_LO;
            RUN: if (ann_done) state_nx = IDLE;
                 else if (req_v) begin
                     state_nx = sel_ok ? REQ : ERROR;
                     sel_nx   = sel_ok ? req_sel : bus_which_data;
                 end
            default: state_nx = IDLE;
        endcase
        if (state inside {REQ, WAIT_HI, WAIT_LO} && ann_request) begin
            pend_nx     = 1'b1;
            pend_sel_nx = ann_select;
        end
        if (state == RUN || (state == ERROR && start)) pend_nx = 1'b0;
        ld     = (state == WAIT_LO) && (state_nx == RUN);
        finish = (state == RUN) && ann_done;
    end

    // state, saturating wait counter and registered strobes/levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            pend           <= 1'b0;
            pend_sel       <= 2'd0;
            loaded_once    <= 1'b0;
            bus_get_data   <= 1'b0;
            bus_which_data <= 2'd0;
            loaded_pulse   <= 1'b0;
            ann_start      <= 1'b0;
            seven_seg      <= 8'h00;
            done           <= 1'b0;
            error          <= 1'b0;
            active         <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= (state_nx != state) ? '0 :
                              (state inside {WAIT_HI, WAIT_LO} && cnt != '1) ? cnt + CW'(1) : cnt;
            pend           <= pend_nx;
            pend_sel       <= pend_sel_nx;
            loaded_once    <= (state inside {IDLE, ERROR}) ? 1'b0 : (loaded_once | ld);
            bus_get_data   <= state_nx == REQ;
            bus_which_data <= sel_nx;
            loaded_pulse   <= ld;
            ann_start      <= ld && !loaded_once;
            seven_seg      <= finish ? ann_seven_seg : seven_seg;
            done           <= finish;
            error          <= state_nx == ERROR;
            active         <= !(state_nx inside {IDLE, ERROR});
        end
    end
endmodule

// File: tb/tb_ann_load_scheduler.sv
// tb_ann_load_scheduler: directed and randomized checks of the load scheduler against transfer-level expectations
module tb_ann_load_scheduler;
    localparam int NS = 3;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, bus_busy = 1'b0;
    logic       ann_request = 1'b0, ann_done = 1'b0;
    logic [1:0] ann_select = 2'd0;
    logic [7:0] ann_seven_seg = 8'h00;
    logic       bus_get_data, loaded_pulse, ann_start, done, error, active;
    logic [1:0] bus_which_data;
    logic [7:0] seven_seg;
    int         n_vec = 0, n_err = 0;

    ann_load_scheduler #(.NUM_SETS(NS), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .start(start), .bus_busy(bus_busy),
        .ann_request(ann_request), .ann_select(ann_select), .ann_done(ann_done),
        .ann_seven_seg(ann_seven_seg), .bus_get_data(bus_get_data),
        .bus_which_data(bus_which_data), .loaded_pulse(loaded_pulse),
        .ann_start(ann_start), .seven_seg(seven_seg), .done(done),
        .error(error), .active(active)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {7'b0, obs}, {7'b0, exp});
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        chk(tag, {6'b0, obs}, {6'b0, exp});
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, ".get_data"}, bus_get_data, 1'b0);
        chk2({tag, ".which"}, bus_which_data, 2'd0);
        chk1({tag, ".loaded"}, loaded_pulse, 1'b0);
        chk1({tag, ".ann_start"}, ann_start, 1'b0);
        chk1({tag, ".done"}, done, 1'b0);
        chk1({tag, ".error"}, error, 1'b0);
        chk1({tag, ".active"}, active, 1'b0);
        chk({tag, ".seven_seg"}, seven_seg, 8'h00);
    endtask

    // Entered on the bus_get_data cycle. Busy is high for cycles pre..pre+len-1 after it,
    // so loaded_pulse must appear at cycle pre+len+1. A nonzero 'at' injects an ANN request
    // (select isel) at that wait cycle, preceded by an overwritten one at cycle 1.
    task automatic load(input logic [1:0] sel, input int pre, input int len, input logic first,
                        input int at, input logic [1:0] isel);
        chk1("req.get_data", bus_get_data, 1'b1);
        chk2("req.which", bus_which_data, sel);
        chk1("req.active", active, 1'b1);
        chk1("req.error", error, 1'b0);
        for (int i = 1; i <= pre + len; i++) begin
            step();
            bus_busy    = (i >= pre) && (i < pre + len);
            ann_done    = 1'($urandom_range(0, 1));
            ann_request = (at != 0) && (i == at || i == 1);
            ann_select  = (i == at) ? isel : ~isel;
            chk1("wait.get_data", bus_get_data, 1'b0);
            chk1("wait.loaded", loaded_pulse, 1'b0);
            chk2("wait.which", bus_which_data, sel);
        end
        step();
        bus_busy    = 1'b0;
        ann_done    = 1'b0;
        ann_request = 1'b0;
        chk1("load.loaded", loaded_pulse, 1'b1);
        chk1("load.ann_start", ann_start, first);
        chk2("load.which", bus_which_data, sel);
        chk1("load.active", active, 1'b1);
        chk1("load.get_data", bus_get_data, 1'b0);
    endtask

    task automatic finish_run(input logic [7:0] v, input logic rq, input logic [1:0] rs);
        ann_done      = 1'b1;
        ann_seven_seg = v;
        ann_request   = rq;
        ann_select    = rs;
        step();
        ann_done    = 1'b0;
        ann_request = 1'b0;
        chk1("fin.done", done, 1'b1);
        chk("fin.seven_seg", seven_seg, v);
        chk1("fin.get_data", bus_get_data, 1'b0);
        chk1("fin.active", active, 1'b0);
        chk1("fin.error", error, 1'b0);
        step();
        chk1("fin.done_once", done, 1'b0);
        chk1("fin.get_data2", bus_get_data, 1'b0);
        chk("fin.seven_seg_hold", seven_seg, v);
    endtask

    initial begin
        logic [1:0] sel, nsel;
        logic       first, err_end;
        int         nrel, pre, len, at;
        #3;
        chk_reset("rst");
        step();
        reset = 1'b0;
        step();
        chk_reset("idle");

        // first load of a run: busy cycles 3-7, loaded + ann_start one cycle after busy drops
        start = 1'b1;
        step();
        start = 1'b0;
        load(2'd0, 3, 5, 1'b1, 0, 2'd0);

        // reload of set 2 from RUN without ann_start
        ann_request = 1'b1;
        ann_select  = 2'd2;
        step();
        ann_request = 1'b0;
        load(2'd2, 1, 1, 1'b0, 0, 2'd0);

        // request for set 1 during WAIT_LO is serviced right after the RUN entry cycle
        ann_request = 1'b1;
        ann_select  = 2'd0;
        step();
        ann_request = 1'b0;
        load(2'd0, 2, 3, 1'b0, 4, 2'd1);
        step();
        load(2'd1, 1, 2, 1'b0, 0, 2'd0);

        // done coincident with a request: done wins
        finish_run(8'h5B, 1'b1, 2'd1);

        // out-of-range select goes to ERROR, which holds until start
        start = 1'b1;
        step();
        start = 1'b0;
        load(2'd0, 2, 2, 1'b1, 0, 2'd0);
        ann_request = 1'b1;
        ann_select  = 2'd3;
        step();
        ann_request = 1'b0;
        ann_done    = 1'b1;
        chk1("badsel.error", error, 1'b1);
        chk1("badsel.active", active, 1'b0);
        step();
        ann_done = 1'b0;
        chk1("badsel.error_hold", error, 1'b1);
        chk1("badsel.done_ignored", done, 1'b0);
        chk("badsel.seven_seg", seven_seg, 8'h5B);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            start = 1'b1;
            step();
            start   = 1'b0;
            sel     = 2'd0;
            first   = 1'b1;
            err_end = 1'b0;
            nrel    = int'($urandom_range(0, 3));
            for (int k = 0; k <= nrel; k++) begin
                nsel = 2'($urandom_range(0, 3));
                pre  = int'($urandom_range(1, 8));
                len  = int'($urandom_range(1, 6));
                at   = (k < nrel && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, pre + len)) : 0;
                load(sel, pre, len, first, at, nsel);
                first = 1'b0;
                if (k == nrel) break;
                if (at == 0) begin
                    ann_request = 1'b1;
                    ann_select  = nsel;
                end
                step();
                ann_request = 1'b0;
                if (int'(nsel) >= NS) begin
                    chk1("rnd.bad.error", error, 1'b1);
                    chk1("rnd.bad.active", active, 1'b0);
                    chk1("rnd.bad.get_data", bus_get_data, 1'b0);
                    err_end = 1'b1;
                    break;
                end
                sel = nsel;
            end
            if (!err_end) finish_run(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // bus never goes busy: ERROR exactly 1024 cycles after REQ
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("tmo.get_data", bus_get_data, 1'b1);
        for (int i = 1; i <= 1023; i++) step();
        chk1("tmo.error_early", error, 1'b0);
        chk1("tmo.active_early", active, 1'b1);
        step();
        chk1("tmo.error", error, 1'b1);
        chk1("tmo.active", active, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        load(2'd0, 1, 1, 1'b1, 0, 2'd0);
        finish_run(8'hA7, 1'b0, 2'd0);

        // reset in WAIT_LO abandons the transfer
        start = 1'b1;
        step();
        start = 1'b0;
        load(2'd0, 1, 1, 1'b1, 0, 2'd0);
        ann_request = 1'b1;
        ann_select  = 2'd2;
        step();
        ann_request = 1'b0;
        bus_busy    = 1'b1;
        step();
        step();
        chk2("mid.which", bus_which_data, 2'd2);
        chk1("mid.active", active, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("rst_mid");
        step();
        reset    = 1'b0;
        bus_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("post_rst.loaded", loaded_pulse, 1'b0);
            chk1("post_rst.active", active, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
